// File: rtl/ddc_cap_ctrl_if.sv
// Purpose: capture-control bundle between the DDC/host side and ddc_cap_ctrl.
// Latency: none, wiring only.
// Backpressure: none; strobes and pulses are single-cycle and never stalled.
interface ddc_cap_ctrl_if;
  logic        ddc_valid;
  logic [13:0] ddc_waddr;
  logic        cap_arm;
  logic        cap_abort;
  logic        trig_in;
  logic [13:0] pre_len;
  logic [13:0] post_len;
  logic        ram_wen_enb;
  logic        cap_busy;
  logic        cap_done;
  logic        cap_err;
  logic [13:0] cap_start_addr;
  logic [13:0] cap_trig_addr;
  logic [2:0]  cap_state;

  // Host / datapath side: drives strobes, commands and lengths.
  modport master (
    output ddc_valid, ddc_waddr, cap_arm, cap_abort, trig_in, pre_len, post_len,
    input  ram_wen_enb, cap_busy, cap_done, cap_err, cap_start_addr, cap_trig_addr,
           cap_state
  );

  // Sequencer side.
  modport slave (
    input  ddc_valid, ddc_waddr, cap_arm, cap_abort, trig_in, pre_len, post_len,
    output ram_wen_enb, cap_busy, cap_done, cap_err, cap_start_addr, cap_trig_addr,
           cap_state
  );
endinterface

// File: rtl/ddc_cap_ctrl.sv
// Purpose: capture sequencer for the DDC ring buffer: pre-history, trigger, post samples, then freeze.
// Latency: all outputs registered; arm->busy 1 cycle, trigger strobe->trig addr 1, ->start addr 2.
// Backpressure: none; the ring write is gated by ram_wen_enb. Optional DDC_CAP_TIMEOUT_EN bounds WAIT.
module ddc_cap_ctrl #(
  parameter int          U_DLY       = 1,
  parameter logic [13:0] MAX_ADDR    = 14'd11520,
  parameter logic [31:0] TIMEOUT_SMP = 32'd160000
) (
  input logic           clk_25d6m,
  input logic           rst_n,
  ddc_cap_ctrl_if.slave cap_if
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Ring depth as a 15-bit quantity so MAX_ADDR+1 cannot overflow.
  localparam logic [14:0] RING_LEN = {1'b0, MAX_ADDR} + 15'd1;

  // Registers are assigned without delay; U_DLY is kept for interface compatibility.
  if (U_DLY < 0) begin : g_u_dly_neg
  end

  state_t      r_state;
  logic        r_wen;
  logic        r_busy;
  logic        r_done;
  logic        r_err;
  logic [13:0] r_start_addr;
  logic [13:0] r_trig_addr;
  logic [13:0] r_pre_len;
  logic [13:0] r_post_len;
  logic [13:0] r_cnt;
  logic        r_trig_prev;
  logic        r_trig_pend;
  logic        r_start_upd;
`ifdef DDC_CAP_TIMEOUT_EN
  logic [31:0] r_tmo_cnt;
`else
  // Without the timeout the limit is unused; it is still referenced here.
  if (TIMEOUT_SMP == 32'd0) begin : g_tmo_unused
  end
`endif

  logic        w_trig_edge;
  logic        w_arm_ok;
  logic        w_fire;
  logic [13:0] w_cnt_inc;
  logic [13:0] w_start_addr;

  assign w_trig_edge = cap_if.trig_in & ~r_trig_prev;
  assign w_arm_ok    = (cap_if.post_len != 14'd0) &&
                       (({1'b0, cap_if.pre_len} + {1'b0, cap_if.post_len}) <= RING_LEN);
  assign w_fire      = cap_if.ddc_valid & (r_trig_pend | w_trig_edge);
  assign w_cnt_inc   = r_cnt + 14'd1;
  // Snapshot start walks back pre_len entries from the trigger, wrapping through the ring top.
  assign w_start_addr = (r_trig_addr >= r_pre_len) ? (r_trig_addr - r_pre_len)
                      : 14'({1'b0, r_trig_addr} + RING_LEN - {1'b0, r_pre_len});

  // Capture FSM with all status outputs registered alongside the state.
  always_ff @(posedge clk_25d6m) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wen        <= 1'b1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_start_addr <= 14'd0;
      r_trig_addr  <= 14'd0;
      r_pre_len    <= 14'd0;
      r_post_len   <= 14'd0;
      r_cnt        <= 14'd0;
      r_trig_prev  <= 1'b0;
      r_trig_pend  <= 1'b0;
      r_start_upd  <= 1'b0;
`ifdef DDC_CAP_TIMEOUT_EN
      r_tmo_cnt    <= 32'd0;
`endif
    end else begin
      r_trig_prev <= cap_if.trig_in;
      r_start_upd <= 1'b0;
      if (r_start_upd) begin
        r_start_addr <= w_start_addr;
      end

      if (cap_if.cap_abort) begin
        r_state     <= ST_IDLE;
        r_wen       <= 1'b1;
        r_busy      <= 1'b0;
        r_done      <= 1'b0;
        r_err       <= 1'b0;
        r_trig_pend <= 1'b0;
        r_cnt       <= 14'd0;
      end else begin
        case (r_state)
          ST_IDLE, ST_DONE: begin
            if (cap_if.cap_arm) begin
              if (w_arm_ok) begin
                r_pre_len  <= cap_if.pre_len;
                r_post_len <= cap_if.post_len;
                r_cnt      <= 14'd0;
                r_err      <= 1'b0;
                r_state    <= ST_PRE;
                r_busy     <= 1'b1;
                r_done     <= 1'b0;
                r_wen      <= 1'b1;
              end else begin
                r_err <= 1'b1;
              end
            end
          end

          ST_PRE: begin
            // Trigger edges are deliberately ignored until enough history exists.
            r_trig_pend <= 1'b0;
`ifdef DDC_CAP_TIMEOUT_EN
            r_tmo_cnt   <= 32'd0;
`endif
            if (r_cnt == r_pre_len) begin
              r_state <= ST_WAIT;
            end else if (cap_if.ddc_valid) begin
              r_cnt <= w_cnt_inc;
            end
          end

          ST_WAIT: begin
            if (w_fire) begin
              r_trig_addr <= cap_if.ddc_waddr;
              r_cnt       <= 14'd1;
              r_trig_pend <= 1'b0;
              r_start_upd <= 1'b1;
              if (r_post_len == 14'd1) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_wen   <= 1'b0;
              end else begin
                r_state <= ST_POST;
              end
            end else begin
              if (w_trig_edge) begin
                r_trig_pend <= 1'b1;
              end
`ifdef DDC_CAP_TIMEOUT_EN
              if (cap_if.ddc_valid) begin
                if (r_tmo_cnt + 32'd1 == TIMEOUT_SMP) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                  r_err   <= 1'b1;
                  r_wen   <= 1'b1;
                end else begin
                  r_tmo_cnt <= r_tmo_cnt + 32'd1;
                end
              end
`endif
            end
          end

          ST_POST: begin
            // The completing strobe is still written; the freeze lands on the next edge.
            if (cap_if.ddc_valid) begin
              r_cnt <= w_cnt_inc;
              if (w_cnt_inc == r_post_len) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_wen   <= 1'b0;
              end
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_wen   <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign cap_if.ram_wen_enb    = r_wen;
  assign cap_if.cap_busy       = r_busy;
  assign cap_if.cap_done       = r_done;
  assign cap_if.cap_err        = r_err;
  assign cap_if.cap_start_addr = r_start_addr;
  assign cap_if.cap_trig_addr  = r_trig_addr;
  assign cap_if.cap_state      = r_state;

endmodule

// File: tb/tb_ddc_cap_ctrl.sv
// Directed bench for ddc_cap_ctrl: capture, wrap, ignored PRE edge, length checks,
// abort/rearm, optional trigger timeout, reset mid-capture.
module tb_ddc_cap_ctrl;
  logic clk_25d6m;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  ddc_cap_ctrl_if cap_if ();

  ddc_cap_ctrl #(
    .U_DLY      (1),
    .MAX_ADDR   (14'd11520),
    .TIMEOUT_SMP(32'd8)
  ) u_dut (
    .clk_25d6m(clk_25d6m),
    .rst_n    (rst_n),
    .cap_if   (cap_if.slave)
  );

  initial clk_25d6m = 1'b0;
  always #20 clk_25d6m = ~clk_25d6m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25d6m);
  endtask

  // One strobe, then idle so that the next strobe starts gap cycles later.
  task automatic strobe(input logic [13:0] addr, input int gap);
    cap_if.ddc_valid = 1'b1;
    cap_if.ddc_waddr = addr;
    @(negedge clk_25d6m);
    cap_if.ddc_valid = 1'b0;
    if (gap > 1) tick(gap - 1);
  endtask

  task automatic arm(input logic [13:0] pre, input logic [13:0] post);
    cap_if.pre_len  = pre;
    cap_if.post_len = post;
    cap_if.cap_arm  = 1'b1;
    @(negedge clk_25d6m);
    cap_if.cap_arm  = 1'b0;
  endtask

  task automatic abort_pulse();
    cap_if.cap_abort = 1'b1;
    @(negedge clk_25d6m);
    cap_if.cap_abort = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    cap_if.ddc_valid = 1'b0;
    cap_if.ddc_waddr = 14'd0;
    cap_if.cap_arm   = 1'b0;
    cap_if.cap_abort = 1'b0;
    cap_if.trig_in   = 1'b0;
    cap_if.pre_len   = 14'd0;
    cap_if.post_len  = 14'd0;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset values
    chk("rst_state", cap_if.cap_state, 0);
    chk("rst_wen", cap_if.ram_wen_enb, 1);
    chk("rst_busy", cap_if.cap_busy, 0);
    chk("rst_done", cap_if.cap_done, 0);
    chk("rst_err", cap_if.cap_err, 0);
    chk("rst_start", cap_if.cap_start_addr, 0);
    chk("rst_trig", cap_if.cap_trig_addr, 0);

    // Main capture: pre=100, post=200, strobe every 160 cycles, trigger at strobe 150 (addr 5000)
    arm(14'd100, 14'd200);
    chk("t1_busy", cap_if.cap_busy, 1);
    chk("t1_state_pre", cap_if.cap_state, 1);
    for (int n = 1; n <= 149; n++) strobe(14'(4850 + n), 160);
    chk("t1_state_wait", cap_if.cap_state, 2);
    cap_if.trig_in = 1'b1;
    strobe(14'd5000, 1);
    chk("t1_trig_addr", cap_if.cap_trig_addr, 5000);
    chk("t1_state_post", cap_if.cap_state, 3);
    tick(1);
    chk("t1_start_addr", cap_if.cap_start_addr, 4900);
    cap_if.trig_in = 1'b0;
    tick(158);
    for (int k = 1; k <= 198; k++) strobe(14'(5000 + k), 160);
    chk("t1_wen_before_last", cap_if.ram_wen_enb, 1);
    chk("t1_done_before_last", cap_if.cap_done, 0);
    strobe(14'd5199, 1);
    chk("t1_wen_frozen", cap_if.ram_wen_enb, 0);
    chk("t1_done", cap_if.cap_done, 1);
    chk("t1_state_done", cap_if.cap_state, 4);
    chk("t1_busy_off", cap_if.cap_busy, 0);

    // Rearm from DONE; pending trigger; start address wraps (trig 30, pre 100 -> 11451)
    arm(14'd100, 14'd5);
    chk("t2_state_pre", cap_if.cap_state, 1);
    chk("t2_wen", cap_if.ram_wen_enb, 1);
    chk("t2_done_clr", cap_if.cap_done, 0);
    for (int i = 0; i < 100; i++) strobe(14'(i), 4);
    tick(2);
    chk("t2_state_wait", cap_if.cap_state, 2);
    cap_if.trig_in = 1'b1;
    tick(2);
    cap_if.trig_in = 1'b0;
    tick(2);
    chk("t2_still_wait", cap_if.cap_state, 2);
    strobe(14'd30, 1);
    chk("t2_trig_addr", cap_if.cap_trig_addr, 30);
    tick(1);
    chk("t2_start_wrap", cap_if.cap_start_addr, 11451);
    for (int i = 31; i <= 33; i++) strobe(14'(i), 4);
    strobe(14'd34, 1);
    chk("t2_state_done", cap_if.cap_state, 4);

    // Edge in PRE ignored; second edge in WAIT captures; post=1 finishes on the trigger strobe
    abort_pulse();
    chk("t3_abort_state", cap_if.cap_state, 0);
    chk("t3_abort_wen", cap_if.ram_wen_enb, 1);
    chk("t3_abort_done", cap_if.cap_done, 0);
    arm(14'd50, 14'd1);
    for (int i = 1; i <= 9; i++) strobe(14'(i), 4);
    cap_if.trig_in = 1'b1;
    strobe(14'd10, 4);
    cap_if.trig_in = 1'b0;
    for (int i = 11; i <= 50; i++) strobe(14'(i), 4);
    chk("t3_state_wait", cap_if.cap_state, 2);
    chk("t3_trig_unchanged", cap_if.cap_trig_addr, 30);
    cap_if.trig_in = 1'b1;
    strobe(14'd777, 1);
    cap_if.trig_in = 1'b0;
    chk("t3_state_done", cap_if.cap_state, 4);
    chk("t3_trig_addr", cap_if.cap_trig_addr, 777);
    chk("t3_wen_frozen", cap_if.ram_wen_enb, 0);
    tick(1);
    chk("t3_start_addr", cap_if.cap_start_addr, 727);

    // Length checks, including the exact-fit boundary (11000 + 521 = 11521)
    abort_pulse();
    arm(14'd11000, 14'd600);
    chk("t4_err_too_long", cap_if.cap_err, 1);
    chk("t4_state_idle", cap_if.cap_state, 0);
    chk("t4_busy_off", cap_if.cap_busy, 0);
    abort_pulse();
    chk("t4_err_clr", cap_if.cap_err, 0);
    arm(14'd5, 14'd0);
    chk("t4_err_post0", cap_if.cap_err, 1);
    arm(14'd11000, 14'd521);
    chk("t4_fit_busy", cap_if.cap_busy, 1);
    chk("t4_fit_err_clr", cap_if.cap_err, 0);
    abort_pulse();

    // Abort in POST, then abort+arm in the same cycle
    arm(14'd2, 14'd10);
    strobe(14'd0, 4);
    strobe(14'd1, 4);
    cap_if.trig_in = 1'b1;
    strobe(14'd100, 4);
    cap_if.trig_in = 1'b0;
    strobe(14'd101, 4);
    strobe(14'd102, 4);
    chk("t5_state_post", cap_if.cap_state, 3);
    abort_pulse();
    chk("t5_abort_state", cap_if.cap_state, 0);
    chk("t5_abort_busy", cap_if.cap_busy, 0);
    chk("t5_abort_wen", cap_if.ram_wen_enb, 1);
    arm(14'd0, 14'd3);
    chk("t5_pre0_state", cap_if.cap_state, 1);
    tick(1);
    chk("t5_pre0_wait", cap_if.cap_state, 2);
    cap_if.cap_abort = 1'b1;
    cap_if.cap_arm   = 1'b1;
    tick(1);
    cap_if.cap_abort = 1'b0;
    cap_if.cap_arm   = 1'b0;
    chk("t5_both_state", cap_if.cap_state, 0);
    chk("t5_both_busy", cap_if.cap_busy, 0);
    chk("t5_both_wen", cap_if.ram_wen_enb, 1);

    // Trigger wait with no trigger
    arm(14'd0, 14'd5);
    tick(1);
    chk("t6_state_wait", cap_if.cap_state, 2);
`ifdef DDC_CAP_TIMEOUT_EN
    for (int i = 0; i < 7; i++) strobe(14'(i), 4);
    chk("t6_before_timeout", cap_if.cap_state, 2);
    strobe(14'd7, 1);
    chk("t6_timeout_state", cap_if.cap_state, 0);
    chk("t6_timeout_err", cap_if.cap_err, 1);
    chk("t6_timeout_wen", cap_if.ram_wen_enb, 1);
`else
    for (int i = 0; i < 10; i++) strobe(14'(i), 4);
    chk("t6_wait_persists", cap_if.cap_state, 2);
    chk("t6_no_err", cap_if.cap_err, 0);
`endif
    abort_pulse();

    // Reset while frozen releases the ring on the next edge
    arm(14'd0, 14'd1);
    tick(1);
    cap_if.trig_in = 1'b1;
    strobe(14'd9, 1);
    cap_if.trig_in = 1'b0;
    chk("t7_frozen", cap_if.ram_wen_enb, 0);
    rst_n = 1'b0;
    tick(1);
    chk("t7_rst_state", cap_if.cap_state, 0);
    chk("t7_rst_wen", cap_if.ram_wen_enb, 1);
    chk("t7_rst_done", cap_if.cap_done, 0);
    chk("t7_rst_trig", cap_if.cap_trig_addr, 0);
    chk("t7_rst_start", cap_if.cap_start_addr, 0);
    rst_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
